// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam int unsigned ILEN_BYTES = 4;
  localparam logic [FETCH_XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory request/response, redirect and decode handshake bundle for fetch_unit.
// FETCH_MISALIGN_TRAP_EN adds the misaligned-redirect exception outputs.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            o_im_arvalid;
  logic            i_im_arready;
  logic [XLEN-1:0] o_im_araddr;
  logic            i_im_rvalid;
  logic [XLEN-1:0] i_im_rdata;
  logic            o_im_rready;
  logic            i_br_valid;
  logic [XLEN-1:0] i_br_target;
  logic            o_if_valid;
  logic            i_if_ready;
  logic [XLEN-1:0] o_if_instr;
  logic [XLEN-1:0] o_if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            o_exc_misaligned;
  logic [XLEN-1:0] o_exc_pc;
`endif

  modport master (
    input  i_im_arready, i_im_rvalid, i_im_rdata, i_br_valid, i_br_target, i_if_ready,
    output o_im_arvalid, o_im_araddr, o_im_rready, o_if_valid, o_if_instr, o_if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    , output o_exc_misaligned, o_exc_pc
`endif
  );

  modport slave (
    output i_im_arready, i_im_rvalid, i_im_rdata, i_br_valid, i_br_target, i_if_ready,
    input  o_im_arvalid, o_im_araddr, o_im_rready, o_if_valid, o_if_instr, o_if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    , input o_exc_misaligned, o_exc_pc
`endif
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-2 depth FIFO of fetch_entry_t with synchronous flush.
// Head entry comes straight from storage flops, so a push is visible next cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output fetch_entry_t           data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;

  assign count_o = wr_q - rd_q;
  assign valid_o = (wr_q != rd_q);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      rd_d = wr_q;
    end else begin
      if (push_i) wr_d = wr_q + (AW+1)'(1);
      if (pop_i)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, fetch buffer, redirects.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises o_exc_misaligned and halts fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned     CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(ILEN_BYTES);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            req_fire, resp_fire, credit_ok, halted;
  logic [XLEN-1:0] br_pc;
  logic            fifo_push, fifo_pop, fifo_flush, fifo_valid;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    push_entry, head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            halted_q, halted_d, misaligned, exc_q;
  logic [XLEN-1:0] exc_pc_q;

  assign misaligned = bus.i_br_valid && (bus.i_br_target[1:0] != 2'b00);
  assign br_pc      = bus.i_br_target;
  assign halted_d   = bus.i_br_valid ? misaligned : halted_q;
  assign halted     = halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      exc_q    <= 1'b0;
      exc_pc_q <= '0;
    end else begin
      halted_q <= halted_d;
      exc_q    <= misaligned;
      if (misaligned) exc_pc_q <= bus.i_br_target;
    end
  end

  assign bus.o_exc_misaligned = exc_q;
  assign bus.o_exc_pc         = exc_pc_q;
`else
  assign br_pc  = {bus.i_br_target[XLEN-1:2], 2'b00};
  assign halted = 1'b0;
`endif

  // Outstanding requests plus buffered entries never exceed the FIFO depth,
  // so responses can always be accepted.
  assign credit_ok        = ({1'b0, out_q} + {1'b0, fifo_count}) < DEPTH_C;
  assign bus.o_im_arvalid = !rst && credit_ok && !halted;
  assign bus.o_im_araddr  = pc_q;
  assign bus.o_im_rready  = !rst;

  assign req_fire  = bus.o_im_arvalid && bus.i_im_arready;
  assign resp_fire = bus.i_im_rvalid && bus.o_im_rready;

  assign bus.o_if_valid = !rst && fifo_valid && !bus.i_br_valid;
  assign bus.o_if_pc    = head.pc;
  assign bus.o_if_instr = head.instr;
  assign fifo_pop       = bus.o_if_valid && bus.i_if_ready;
  assign push_entry     = '{pc: resp_pc_q, instr: bus.i_im_rdata};

  always_comb begin
    out_d      = out_q + CW'(req_fire) - CW'(resp_fire);
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (bus.i_br_valid) begin
      // Every request still unanswered after this cycle belongs to the old stream.
      pc_d       = br_pc;
      resp_pc_d  = br_pc;
      drop_d     = out_d;
      fifo_flush = 1'b1;
    end else begin
      if (req_fire) pc_d = pc_q + STEP;
      if (resp_fire) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          fifo_push = 1'b1;
          resp_pc_d = resp_pc_q + STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .valid_o (fifo_valid),
    .data_o  (head),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: latency-configurable memory model, redirects,
// backpressure and a second instance near the top of the address space.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk;
  logic rst;

  fetch_unit_if #(.XLEN(32)) fi  ();
  fetch_unit_if #(.XLEN(32)) fi2 ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk), .rst (rst), .bus (fi.master)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk (clk), .rst (rst), .bus (fi2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory model: in-order responses, fixed latency per request
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    lat     = 1;
  bit    ar_rand = 1'b0;

  initial begin
    fi.i_im_arready = 1'b0;
    fi.i_im_rvalid  = 1'b0;
    fi.i_im_rdata   = '0;
    forever begin
      @(posedge clk); #1;
      fi.i_im_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        fi.i_im_rvalid = 1'b1;
        fi.i_im_rdata  = memf(mq[0].addr);
      end else begin
        fi.i_im_rvalid = 1'b0;
      end
      @(negedge clk);
      if (fi.i_im_rvalid && fi.o_im_rready) void'(mq.pop_front());
      if (fi.o_im_arvalid && fi.i_im_arready)
        mq.push_back('{addr: fi.o_im_araddr, due: cyc + lat});
    end
  end

  // Second instance: 1-cycle memory, record the first three request addresses
  logic [31:0] a2 [3];
  int          n2 = 0;
  bit          pend2 = 1'b0;
  logic [31:0] paddr2 = '0;

  initial begin
    fi2.i_im_arready = 1'b1;
    fi2.i_im_rvalid  = 1'b0;
    fi2.i_im_rdata   = '0;
    forever begin
      @(posedge clk); #1;
      fi2.i_im_rvalid = pend2;
      fi2.i_im_rdata  = memf(paddr2);
      @(negedge clk);
      pend2  = !rst && fi2.o_im_arvalid && fi2.i_im_arready;
      paddr2 = fi2.o_im_araddr;
      if (pend2 && n2 < 3) begin
        a2[n2] = fi2.o_im_araddr;
        n2++;
      end
    end
  end

  // Scoreboard monitor for the main instance
  fetch_entry_t exp_q[$];
  fetch_entry_t e;
  logic [31:0]  exp_req_pc = 32'h0000_0000;
  int           max_occ    = 0;
  int           first_req  = -1;
  int           first_val  = -1;
  bit           hold_pend  = 1'b0;
  logic [31:0]  hold_addr  = '0;
  bit           mark       = 1'b0;
  logic [31:0]  mark_pc;

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_pend)
        check_eq("ar_hold", {fi.o_im_arvalid, fi.o_im_araddr}, {1'b1, hold_addr});
      hold_pend = fi.o_im_arvalid && !fi.i_im_arready && !fi.i_br_valid;
      hold_addr = fi.o_im_araddr;

      if (fi.o_if_valid && fi.i_if_ready) begin
        if (first_val < 0) first_val = cyc;
        if (exp_q.size() == 0) begin
          check_eq("deliver_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("if_pc", fi.o_if_pc, e.pc);
          check_eq("if_instr", fi.o_if_instr, e.instr);
        end
        if (mark) begin
          mark_pc = fi.o_if_pc;
          mark    = 1'b0;
        end
      end

      if (fi.o_im_arvalid && fi.i_im_arready) begin
        if (first_req < 0) first_req = cyc;
        check_eq("araddr", fi.o_im_araddr, exp_req_pc);
        exp_q.push_back('{pc: exp_req_pc, instr: memf(exp_req_pc)});
        exp_req_pc = exp_req_pc + 32'd4;
      end

      if (fi.i_br_valid) begin
        check_eq("br_ifvalid", fi.o_if_valid, 0);
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_req_pc = fi.i_br_target;
`else
        exp_req_pc = {fi.i_br_target[31:2], 2'b00};
`endif
      end

      if (exp_q.size() > max_occ) max_occ = exp_q.size();
    end
  end

  // Called at posedge+2; leaves the bench at posedge+2 of the following cycle
  task automatic redirect(input logic [31:0] tgt);
    mark           = 1'b1;
    mark_pc        = 'x;
    fi.i_br_valid  = 1'b1;
    fi.i_br_target = tgt;
    @(posedge clk); #2;
    fi.i_br_valid  = 1'b0;
  endtask

  task automatic wait_mark(input string tag, input logic [31:0] exp_pc);
    for (int i = 0; i < 60 && mark; i++) @(posedge clk);
    #2;
    check_eq(tag, mark_pc, exp_pc);
  endtask

  bit found;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    fi.i_br_valid   = 1'b0;
    fi.i_br_target  = '0;
    fi.i_if_ready   = 1'b1;
    fi2.i_br_valid  = 1'b0;
    fi2.i_br_target = '0;
    fi2.i_if_ready  = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_arvalid", fi.o_im_arvalid, 0);
    check_eq("rst_ifvalid", fi.o_if_valid, 0);
    check_eq("rst_rready",  fi.o_im_rready, 0);
    check_eq("rst_instr",   fi.o_if_instr, 0);
    check_eq("rst_pc",      fi.o_if_pc, 0);

    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_eq("first_arvalid", fi.o_im_arvalid, 1);
    check_eq("first_araddr",  fi.o_im_araddr, 32'h0);
    check_eq("post_rst_rready", fi.o_im_rready, 1);

    repeat (30) @(posedge clk);
    check_eq("first_lat", first_val - first_req, 2);

    // Decode stall: credits cap buffering at the FIFO depth
    @(posedge clk); #2;
    fi.i_if_ready = 1'b0;
    max_occ = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("stall_arvalid", fi.o_im_arvalid, 0);
    check_eq("stall_ifvalid", fi.o_if_valid, 1);
    check_eq("stall_occ", max_occ, 2);
    @(posedge clk); #2;
    fi.i_if_ready = 1'b1;
    repeat (20) @(posedge clk);

    // Random memory and decode backpressure
    ar_rand = 1'b1;
    repeat (80) begin
      @(posedge clk); #2;
      fi.i_if_ready = 1'($urandom_range(0, 1));
    end
    ar_rand = 1'b0;
    fi.i_if_ready = 1'b1;
    repeat (5) @(posedge clk);

    // Latency 3, redirect with two requests outstanding
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (mq.size() == 2) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t3_two_out", found, 1);
    redirect(32'h0000_0100);
    wait_mark("t3_redir_pc", 32'h0000_0100);

    // Redirect coinciding with both a request fire and a response fire
    lat = 1;
    repeat (6) @(posedge clk);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (fi.o_im_arvalid && fi.i_im_arready && fi.i_im_rvalid) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t4_both_fire", found, 1);
    redirect(32'h0000_0300);
    wait_mark("t4_redir_pc", 32'h0000_0300);

    // Back-to-back redirects: the later one wins
    repeat (4) @(posedge clk);
    #2;
    redirect(32'h0000_0400);
    redirect(32'h0000_0500);
    wait_mark("b2b_redir_pc", 32'h0000_0500);

    // Misaligned redirect target
    repeat (4) @(posedge clk);
    #2;
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect(32'h0000_0102);
    @(negedge clk);
    check_eq("exc_pulse", fi.o_exc_misaligned, 1);
    check_eq("exc_pc", fi.o_exc_pc, 32'h0000_0102);
    check_eq("halt_arvalid0", fi.o_im_arvalid, 0);
    @(negedge clk);
    check_eq("exc_pulse_end", fi.o_exc_misaligned, 0);
    repeat (5) begin
      @(negedge clk);
      check_eq("halt_arvalid", fi.o_im_arvalid, 0);
    end
    @(posedge clk); #2;
    redirect(32'h0000_0200);
    wait_mark("unhalt_pc", 32'h0000_0200);
`else
    redirect(32'h0000_0102);
    wait_mark("misalign_pc", 32'h0000_0100);
`endif

    repeat (10) @(posedge clk);

    check_eq("wrap_count", n2 >= 3, 1);
    check_eq("wrap_addr0", a2[0], 32'hFFFF_FFF8);
    check_eq("wrap_addr1", a2[1], 32'hFFFF_FFFC);
    check_eq("wrap_addr2", a2[2], 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
